// File: rtl/vga_avalon_fifo.sv
// rtl/vga_avalon_fifo.sv - Avalon-MM pixel-plot FIFO and screen-fill engine feeding a VGA adapter
// Optional feature: define VGA_AVALON_CLIP_COUNT_EN for a saturating out-of-bounds plot counter at address 3.
module vga_avalon_fifo #(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int COLOUR_W   = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          address,
  input  logic                read,
  output logic [31:0]         readdata,
  input  logic                write,
  input  logic [31:0]         writedata,
  output logic                waitrequest,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = X_W + Y_W + COLOUR_W;

  typedef enum logic [1:0] {IDLE, DRAIN, FILL} state_t;
  state_t state;

  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                fifo_empty, fifo_full, busy;
  logic [X_W-1:0]      wr_x;
  logic [Y_W-1:0]      wr_y;
  logic [COLOUR_W-1:0] wr_colour;
  logic                in_bounds, push, pop, fill_accept, fill_last;
  logic [X_W-1:0]      fill_x;
  logic [Y_W-1:0]      fill_y;
  logic [COLOUR_W-1:0] fill_colour;
  logic                unused_bits;

  assign wr_x        = writedata[16 +: X_W];
  assign wr_y        = writedata[24 +: Y_W];
  assign wr_colour   = writedata[COLOUR_W-1:0];
  assign unused_bits = ^writedata;

  assign in_bounds  = (int'(wr_x) < SCREEN_W) && (int'(wr_y) < SCREEN_H);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign busy       = (state != IDLE);

  // A push uses the full flag from the start of the cycle, so a same-cycle pop never lets it through
  assign push        = write && (address == 4'd0) && in_bounds && !fifo_full && !busy;
  assign pop         = !fifo_empty && (state != FILL);
  assign fill_accept = write && (address == 4'd2) && !busy;
  assign fill_last   = (fill_x == X_W'(SCREEN_W - 1)) && (fill_y == Y_W'(SCREEN_H - 1));

  // Hold the master only for in-bounds plots that cannot be queued yet, or fills while busy
  always_comb begin
    waitrequest = 1'b0;
    if (write) begin
      case (address)
        4'd0:    waitrequest = in_bounds && (fifo_full || busy);
        4'd2:    waitrequest = busy;
        default: waitrequest = 1'b0;
      endcase
    end
  end

  // Pixel storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_x, wr_y, wr_colour};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // Fill sequencer plus the registered pixel port, fed by a FIFO pop or the fill raster counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      fill_x      <= '0;
      fill_y      <= '0;
      fill_colour <= '0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      vga_plot    <= 1'b0;
    end else begin
      vga_plot <= 1'b0;
      if (pop) begin
        {vga_x, vga_y, vga_colour} <= mem[rd_ptr];
        vga_plot <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (fill_accept) begin
            fill_colour <= wr_colour;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty) state <= FILL;
        end
        FILL: begin
          vga_x      <= fill_x;
          vga_y      <= fill_y;
          vga_colour <= fill_colour;
          vga_plot   <= 1'b1;
          if (fill_last) begin
            fill_x <= '0;
            fill_y <= '0;
            state  <= IDLE;
          end else if (fill_x == X_W'(SCREEN_W - 1)) begin
            fill_x <= '0;
            fill_y <= fill_y + Y_W'(1);
          end else begin
            fill_x <= fill_x + X_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VGA_AVALON_CLIP_COUNT_EN
  logic [31:0] clip_count;

  // Count discarded out-of-bounds plots, saturating; a clear write beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (reset) begin
      clip_count <= '0;
    end else if (write && (address == 4'd3)) begin
      clip_count <= '0;
    end else if (write && (address == 4'd0) && !in_bounds && (clip_count != 32'hFFFF_FFFF)) begin
      clip_count <= clip_count + 32'd1;
    end
  end
`endif

  // Zero-latency register reads reflecting state at the start of the cycle
  always_comb begin
    readdata = '0;
    if (read) begin
      case (address)
        4'd1:    readdata = {16'd0, 8'(count), 5'd0, busy, fifo_full, fifo_empty};
`ifdef VGA_AVALON_CLIP_COUNT_EN
        4'd3:    readdata = clip_count;
`endif
        default: readdata = '0;
      endcase
    end
  end
endmodule
